// File: rtl/gf2n_pkg.sv
// Shared GF(2^N) arithmetic helpers, share/randomness width helpers and the
// handshake state encoding used by the masked multipliers.
package gf2n_pkg;

    localparam logic [4:0] GF2N_DEFAULT_POLY = 5'h13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } hs_state_e;

    function automatic int unsigned gf2n_npair(input int unsigned shares);
        return (shares * (shares - 1)) / 2;
    endfunction

    function automatic int unsigned gf2n_nb(input int unsigned n, input int unsigned shares,
                                            input int unsigned foo);
        return ((foo != 0) && (shares == 2)) ? n : n * shares;
    endfunction

    // Linear index of share pair (i,j), i<j, in the per-channel Z vector.
    function automatic int unsigned gf2n_pair_idx(input int unsigned i, input int unsigned j,
                                                  input int unsigned shares);
        return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
    endfunction

    // Shift-and-add multiply with per-step reduction; operands must be below 2^n.
    function automatic logic [31:0] gf2n_mul(input logic [31:0] a, input logic [31:0] b,
                                             input int unsigned n, input logic [32:0] poly);
        logic [32:0] aa;
        logic [31:0] acc;
        acc = '0;
        aa  = {1'b0, a};
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < n) begin
                if (((b >> i) & 32'd1) != 32'd0) begin
                    acc = acc ^ aa[31:0];
                end
                aa = aa << 1;
                if ((aa >> n) != 33'd0) begin
                    aa = aa ^ poly;
                end
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/dom_indep_mul_gf2n.sv
// One-cycle DOM-indep shared multiplier X*Y over GF(2^N): every share product is
// registered (cross terms remasked with Z) before shares are recombined.
module dom_indep_mul_gf2n
    import gf2n_pkg::*;
#(
    parameter int unsigned N      = 4,
    parameter logic [N:0]  POLY   = GF2N_DEFAULT_POLY,
    parameter int unsigned SHARES = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en_i,
    input  logic [SHARES*N-1:0]                 x_i,
    input  logic [SHARES*N-1:0]                 y_i,
    input  logic [gf2n_npair(SHARES)*N-1:0]     z_i,
    output logic [SHARES*N-1:0]                 prod_c
);

    localparam int unsigned TW = SHARES * SHARES * N;

    function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(gf2n_mul(32'(a), 32'(b), N, 33'(POLY)));
    endfunction

    logic [TW-1:0] term_new;
    logic [TW-1:0] term_d;
    logic [TW-1:0] term_q;

    for (genvar i = 0; i < SHARES; i++) begin : g_row
        for (genvar j = 0; j < SHARES; j++) begin : g_col
            localparam int unsigned IDX = (i * SHARES + j) * N;
            if (i == j) begin : g_diag
                assign term_new[IDX +: N] = fmul(x_i[i*N +: N], y_i[j*N +: N]);
            end else begin : g_cross
                localparam int unsigned P = (i < j) ? gf2n_pair_idx(i, j, SHARES)
                                                    : gf2n_pair_idx(j, i, SHARES);
                assign term_new[IDX +: N] = fmul(x_i[i*N +: N], y_i[j*N +: N]) ^ z_i[P*N +: N];
            end
        end

        // Share i recombines only registered terms of its own row.
        logic [N-1:0] row_c;
        always_comb begin
            row_c = '0;
            for (int j = 0; j < SHARES; j++) begin
                row_c = row_c ^ term_q[(i*SHARES + j)*N +: N];
            end
        end
        assign prod_c[i*N +: N] = row_c;
    end

    always_comb begin
        term_d = term_q;
        if (en_i) begin
            term_d = term_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_q <= '0;
        end else begin
            term_q <= term_d;
        end
    end

endmodule

// File: rtl/dom_shared_mul_gf2n_multi.sv
// Masked DOM-indep GF(2^N) multiplier: CHANNELS X operands times one shared Y,
// with valid/ready handshake, accept-gated randomness and optional X/Y pipelining.
module dom_shared_mul_gf2n_multi
    import gf2n_pkg::*;
#(
    parameter int unsigned N                        = 4,
    parameter logic [N:0]  POLY                     = GF2N_DEFAULT_POLY,
    parameter int unsigned SHARES                   = 2,
    parameter int unsigned CHANNELS                 = 2,
    parameter int unsigned PIPELINED                = 1,
    parameter int unsigned FIRST_ORDER_OPTIMIZATION = 1
) (
    input  logic                                                    ClkxCI,
    input  logic                                                    RstxBI,
    input  logic                                                    InValidxSI,
    output logic                                                    InReadyxSO,
    input  logic [CHANNELS*SHARES*N-1:0]                            _XxDI,
    input  logic [SHARES*N-1:0]                                     _YxDI,
    input  logic [CHANNELS*gf2n_npair(SHARES)*N-1:0]                _ZxDI,
    input  logic [gf2n_nb(N, SHARES, FIRST_ORDER_OPTIMIZATION)-1:0] _BxDI,
    output logic                                                    OutValidxSO,
    output logic [CHANNELS*SHARES*N-1:0]                            _QxDO
);

    localparam int unsigned NPAIR   = gf2n_npair(SHARES);
    localparam int unsigned XW      = CHANNELS * SHARES * N;
    localparam bit          USE_FOO = (FIRST_ORDER_OPTIMIZATION != 0) && (SHARES == 2);

    function automatic logic [N-1:0] fmul(input logic [N-1:0] a, input logic [N-1:0] b);
        return N'(gf2n_mul(32'(a), 32'(b), N, 33'(POLY)));
    endfunction

    logic          accept_c;
    logic          out_valid_d;
    logic          out_valid_q;
    logic [XW-1:0] xp;
    logic [XW-1:0] q_raw;

    assign accept_c = InValidxSI & InReadyxSO;

    // Handshake: always ready when pipelined, otherwise one op per IDLE/HOLD pair.
    if (PIPELINED != 0) begin : g_ready_pipe
        assign InReadyxSO = 1'b1;
    end else begin : g_ready_fsm
        hs_state_e state_q;
        hs_state_e state_d;

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE: if (InValidxSI) state_d = ST_HOLD;
                ST_HOLD: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                state_q <= ST_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        assign InReadyxSO = (state_q == ST_IDLE);
    end

    assign out_valid_d = accept_c;

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    assign OutValidxSO = out_valid_q;
    assign _QxDO       = out_valid_q ? q_raw : '0;

    if (PIPELINED != 0) begin : g_xreg
        logic [XW-1:0] x_d;
        logic [XW-1:0] x_q;

        always_comb x_d = accept_c ? _XxDI : x_q;

        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                x_q <= '0;
            end else begin
                x_q <= x_d;
            end
        end

        assign xp = x_q;
    end else begin : g_xlive
        assign xp = _XxDI;
    end

    if (USE_FOO) begin : g_foo
        logic [2*N-1:0] yp;
        logic [2*N-1:0] by_new;
        logic [2*N-1:0] by_d;
        logic [2*N-1:0] by_q;
        logic [XW-1:0]  r_new;
        logic [XW-1:0]  r_d;
        logic [XW-1:0]  r_q;

        if (PIPELINED != 0) begin : g_yreg
            logic [2*N-1:0] y_d;
            logic [2*N-1:0] y_q;

            always_comb y_d = accept_c ? _YxDI : y_q;

            always_ff @(posedge ClkxCI or negedge RstxBI) begin
                if (!RstxBI) begin
                    y_q <= '0;
                end else begin
                    y_q <= y_d;
                end
            end

            assign yp = y_q;
        end else begin : g_ylive
            assign yp = _YxDI;
        end

        // Each share's blinded Y carries the other share, so Y'_s ^ BY_s = Y ^ B.
        assign by_new[0 +: N] = _YxDI[N +: N] ^ _BxDI[0 +: N];
        assign by_new[N +: N] = _YxDI[0 +: N] ^ _BxDI[0 +: N];

        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            for (genvar s = 0; s < 2; s++) begin : g_sh
                localparam int unsigned IDX = (c * 2 + s) * N;
                assign r_new[IDX +: N] = fmul(_XxDI[IDX +: N], _BxDI[0 +: N])
                                       ^ _ZxDI[c*NPAIR*N +: N];
                assign q_raw[IDX +: N] = fmul(xp[IDX +: N], yp[s*N +: N] ^ by_q[s*N +: N])
                                       ^ r_q[IDX +: N];
            end
        end

        always_comb begin
            by_d = by_q;
            r_d  = r_q;
            if (accept_c) begin
                by_d = by_new;
                r_d  = r_new;
            end
        end

        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                by_q <= '0;
                r_q  <= '0;
            end else begin
                by_q <= by_d;
                r_q  <= r_d;
            end
        end
    end else begin : g_gen
        logic [SHARES*N-1:0] by_d;
        logic [SHARES*N-1:0] by_q;
        logic [N-1:0]        sum_c;
        logic [XW-1:0]       t_c;

        always_comb by_d = accept_c ? (_YxDI ^ _BxDI) : by_q;

        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                by_q <= '0;
            end else begin
                by_q <= by_d;
            end
        end

        // Unmasked Y ^ sum(B) is only formed from registered, blinded shares.
        always_comb begin
            sum_c = '0;
            for (int s = 0; s < SHARES; s++) begin
                sum_c = sum_c ^ by_q[s*N +: N];
            end
        end

        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            dom_indep_mul_gf2n #(
                .N      (N),
                .POLY   (POLY),
                .SHARES (SHARES)
            ) u_xb (
                .clk    (ClkxCI),
                .rst_n  (RstxBI),
                .en_i   (accept_c),
                .x_i    (_XxDI[c*SHARES*N +: SHARES*N]),
                .y_i    (_BxDI),
                .z_i    (_ZxDI[c*NPAIR*N +: NPAIR*N]),
                .prod_c (t_c[c*SHARES*N +: SHARES*N])
            );

            for (genvar s = 0; s < SHARES; s++) begin : g_sh
                localparam int unsigned IDX = (c * SHARES + s) * N;
                assign q_raw[IDX +: N] = fmul(xp[IDX +: N], sum_c) ^ t_c[IDX +: N];
            end
        end
    end

endmodule

// File: tb/tb_dom_shared_mul_gf2n_multi.sv
// Scoreboard bench: default pipelined FOO instance plus an unpipelined 3-share
// GF(2^8) instance, both checked on the unmasked XOR of result shares.
module tb_dom_shared_mul_gf2n_multi;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic        a_in_valid, a_in_ready, a_out_valid;
    logic [15:0] a_x, a_q;
    logic [7:0]  a_y, a_z;
    logic [3:0]  a_b;

    logic        b_in_valid, b_in_ready, b_out_valid;
    logic [71:0] b_x, b_z, b_q;
    logic [23:0] b_y, b_b;

    logic [7:0]  a_exp_q[$];
    logic [23:0] b_exp_q[$];

    dom_shared_mul_gf2n_multi u_a (
        .ClkxCI      (clk),
        .RstxBI      (rst_n),
        .InValidxSI  (a_in_valid),
        .InReadyxSO  (a_in_ready),
        ._XxDI       (a_x),
        ._YxDI       (a_y),
        ._ZxDI       (a_z),
        ._BxDI       (a_b),
        .OutValidxSO (a_out_valid),
        ._QxDO       (a_q)
    );

    dom_shared_mul_gf2n_multi #(
        .N                        (8),
        .POLY                     (9'h11B),
        .SHARES                   (3),
        .CHANNELS                 (3),
        .PIPELINED                (0),
        .FIRST_ORDER_OPTIMIZATION (0)
    ) u_b (
        .ClkxCI      (clk),
        .RstxBI      (rst_n),
        .InValidxSI  (b_in_valid),
        .InReadyxSO  (b_in_ready),
        ._XxDI       (b_x),
        ._YxDI       (b_y),
        ._ZxDI       (b_z),
        ._BxDI       (b_b),
        .OutValidxSO (b_out_valid),
        ._QxDO       (b_q)
    );

    // Reference: carry-less product, then polynomial long-division remainder.
    function automatic int ref_mul(input int a, input int b, input int n, input int poly);
        int p;
        p = 0;
        for (int i = 0; i < n; i++) if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int k = 2 * n - 2; k >= n; k--) if (((p >> k) & 1) != 0) p = p ^ (poly << (k - n));
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] a_model();
        logic [7:0] r;
        int y, xv;
        y = int'(a_y[3:0] ^ a_y[7:4]);
        for (int c = 0; c < 2; c++) begin
            xv = int'(a_x[c*8 +: 4] ^ a_x[c*8+4 +: 4]);
            r[c*4 +: 4] = 4'(ref_mul(xv, y, 4, 'h13));
        end
        return r;
    endfunction

    function automatic logic [7:0] a_unmask_q();
        logic [7:0] r;
        for (int c = 0; c < 2; c++) r[c*4 +: 4] = a_q[c*8 +: 4] ^ a_q[c*8+4 +: 4];
        return r;
    endfunction

    function automatic logic [23:0] b_model();
        logic [23:0] r;
        int y, xv;
        y = int'(b_y[0 +: 8] ^ b_y[8 +: 8] ^ b_y[16 +: 8]);
        for (int c = 0; c < 3; c++) begin
            xv = int'(b_x[c*24 +: 8] ^ b_x[c*24+8 +: 8] ^ b_x[c*24+16 +: 8]);
            r[c*8 +: 8] = 8'(ref_mul(xv, y, 8, 'h11B));
        end
        return r;
    endfunction

    function automatic logic [23:0] b_unmask_q();
        logic [23:0] r;
        for (int c = 0; c < 3; c++) r[c*8 +: 8] = b_q[c*24 +: 8] ^ b_q[c*24+8 +: 8] ^ b_q[c*24+16 +: 8];
        return r;
    endfunction

    task automatic a_set(input logic [3:0] x0, input logic [3:0] x1, input logic [3:0] y,
                         input bit zero_rnd);
        logic [3:0] m0, m1, my;
        m0 = 4'($urandom);
        m1 = 4'($urandom);
        my = 4'($urandom);
        a_x = {x1 ^ m1, m1, x0 ^ m0, m0};
        a_y = {y ^ my, my};
        a_z = zero_rnd ? 8'h00 : 8'($urandom);
        a_b = zero_rnd ? 4'h0 : 4'($urandom);
        a_in_valid = 1'b1;
    endtask

    task automatic a_clock(input bit use_forced, input logic [7:0] forced);
        bit acc;
        acc = a_in_valid && a_in_ready;
        @(posedge clk);
        if (acc) a_exp_q.push_back(use_forced ? forced : a_model());
        #1;
    endtask

    task automatic b_rnd_only();
        b_z = {8'($urandom), 32'($urandom), 32'($urandom)};
        b_b = 24'($urandom);
    endtask

    task automatic b_set(input logic [23:0] xv, input logic [7:0] yv);
        logic [7:0] m0, m1;
        for (int c = 0; c < 3; c++) begin
            m0 = 8'($urandom);
            m1 = 8'($urandom);
            b_x[c*24 +: 8]      = m0;
            b_x[c*24+8 +: 8]    = m1;
            b_x[c*24+16 +: 8]   = xv[c*8 +: 8] ^ m0 ^ m1;
        end
        m0 = 8'($urandom);
        m1 = 8'($urandom);
        b_y = {yv ^ m0 ^ m1, m1, m0};
        b_rnd_only();
        b_in_valid = 1'b1;
    endtask

    task automatic b_clock(input bit use_forced, input logic [23:0] forced);
        bit acc;
        acc = b_in_valid && b_in_ready;
        @(posedge clk);
        if (acc) b_exp_q.push_back(use_forced ? forced : b_model());
        #1;
    endtask

    // Monitor: pop the expected result whenever a DUT presents one.
    logic [7:0]  a_e;
    logic [23:0] b_e;
    always @(negedge clk) begin
        if (rst_n && a_out_valid) begin
            if (a_exp_q.size() == 0) begin
                check("a_spurious_valid", 32'(a_out_valid), 32'd0);
            end else begin
                a_e = a_exp_q.pop_front();
                check("a_result", 32'(a_unmask_q()), 32'(a_e));
            end
        end
        if (rst_n && b_out_valid) begin
            if (b_exp_q.size() == 0) begin
                check("b_spurious_valid", 32'(b_out_valid), 32'd0);
            end else begin
                b_e = b_exp_q.pop_front();
                check("b_result", 32'(b_unmask_q()), 32'(b_e));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gaps;
        rst_n      = 1'b0;
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        a_x = 16'h5A3C; a_y = 8'h71; a_z = 8'h00; a_b = 4'h0;
        b_x = {8'h12, 32'h3456789A, 32'hBCDEF013};
        b_y = 24'h83A5C7;
        b_rnd_only();
        repeat (3) @(posedge clk);
        #1;
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_a_q", 32'(a_q), 32'd0);
        check("post_rst_b_q", 32'(b_q[31:0] | b_q[71:32]), 32'd0);
        check("post_rst_a_ready", 32'(a_in_ready), 32'd1);
        check("post_rst_b_ready", 32'(b_in_ready), 32'd1);

        // Worked example: Q0 -> 0x3, Q1 -> 0x8.
        a_x = 16'h0157; a_y = 8'h4C; a_z = 8'h63; a_b = 4'hA;
        a_in_valid = 1'b1;
        a_clock(1'b1, 8'h83);

        // Y unmasks to zero: both channels give zero.
        repeat (6) begin
            a_set(4'($urandom), 4'($urandom), 4'h0, 1'b0);
            a_clock(1'b1, 8'h00);
        end

        // No fresh randomness at all still yields the correct product.
        repeat (6) begin
            a_set(4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
            a_clock(1'b0, 8'h00);
        end

        // Long back-to-back run: OutValid must never drop.
        gaps = 0;
        for (int i = 0; i < 1000; i++) begin
            a_set(4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
            a_clock(1'b0, 8'h00);
            if (a_out_valid !== 1'b1) gaps++;
        end
        check("a_valid_continuous", 32'(gaps), 32'd0);
        a_in_valid = 1'b0;
        a_clock(1'b0, 8'h00);
        a_clock(1'b0, 8'h00);

        // Reset in the cycle after an accept drops the pending result.
        a_set(4'h9, 4'h6, 4'hB, 1'b0);
        a_clock(1'b0, 8'h00);
        a_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_a_q", 32'(a_q), 32'd0);
        a_exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("midrst_a_ready", 32'(a_in_ready), 32'd1);
        check("midrst_b_ready", 32'(b_in_ready), 32'd1);
        a_set(4'hE, 4'h3, 4'h5, 1'b0);
        a_clock(1'b0, 8'h00);
        a_in_valid = 1'b0;
        a_clock(1'b0, 8'h00);

        // 3-share GF(2^8): 0x57 * 0x83 = 0xC1 in every channel.
        b_set({8'h57, 8'h57, 8'h57}, 8'h83);
        b_clock(1'b1, 24'hC1C1C1);
        b_rnd_only();
        b_clock(1'b0, 24'h0);
        b_in_valid = 1'b0;
        b_clock(1'b0, 24'h0);

        // InValid held for 6 cycles: ready/valid alternate, three ops complete.
        for (int k = 0; k < 6; k++) begin
            if ((k % 2) == 0) b_set(24'($urandom), 8'($urandom));
            else b_rnd_only();
            check("b_ready_pattern", 32'(b_in_ready), 32'((k % 2) == 0));
            check("b_valid_pattern", 32'(b_out_valid), 32'((k % 2) == 1));
            b_clock(1'b0, 24'h0);
        end

        // Random ops; X/Y stay stable through each HOLD cycle.
        repeat (20) begin
            b_set(24'($urandom), 8'($urandom));
            b_clock(1'b0, 24'h0);
            b_rnd_only();
            b_clock(1'b0, 24'h0);
        end
        b_in_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            if (a_exp_q.size() == 0 && b_exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("queues_drained", 32'(a_exp_q.size() + b_exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
